ftdi_async_fifo_if: RTL and testbench

//  Drives the FTDI FT232H-class USB FIFO in async 245 mode: owns fifo_d, fifo_rd_n, fifo_wr_n, fifo_siwu and fifo_oe_n.

---
 rtl/ftdi_pkg.sv | 23 ++
 rtl/ftdi_async_fifo_if_sync_ff.sv | 28 ++
 rtl/ftdi_async_fifo_if.sv | 195 +++++++++++++++++++
 tb/tb_ftdi_async_fifo_if.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_pkg.sv
// Shared types and defaults for the FT232H async-245 FIFO interface.
package ftdi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdStrobe,
        StRdLatch,
        StWrSetup,
        StWrStrobe,
        StRecover
    } ftdi_state_e;

    typedef enum logic {
        LastRd,
        LastWr
    } last_op_e;

    localparam int unsigned FTDI_RD_CYCLES     = 2;
    localparam int unsigned FTDI_WR_CYCLES     = 3;
    localparam int unsigned RECOVER_CYCLES_DEF = 3;
    localparam int unsigned SYNC_STAGES_DEF    = 2;

endpackage

// File: rtl/ftdi_async_fifo_if_sync_ff.sv
// 1-bit multi-stage synchroniser for asynchronous active-low flags; resets to 1 (inactive).
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_d;
    logic [STAGES-1:0] sync_q;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ftdi_async_fifo_if.sv
// FT232H async-245 FIFO driver: RX/TX valid/ready streams to RD#/WR# strobes.
// Define FTDI_SIWU_EN to enable the tx_flush -> SIWU# send-immediate pulse.
module ftdi_async_fifo_if
    import ftdi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int unsigned RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
    input  logic       clk_12mhz,
    input  logic       reset_n,
    input  logic [7:0] fifo_d_in,
    output logic [7:0] fifo_d_out,
    output logic       fifo_d_oe,
    input  logic       fifo_rxf_n,
    input  logic       fifo_txe_n,
    output logic       fifo_rd_n,
    output logic       fifo_wr_n,
    output logic       fifo_siwu,
    output logic       fifo_oe_n,
    input  logic       usb_pwren_n,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       tx_flush
);

    localparam int unsigned     CntW    = $clog2(RECOVER_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(RECOVER_CYCLES - 1);

    logic rxf_s, txe_s, pwren_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rxf (
        .clk_i (clk_12mhz),
        .rst_ni(reset_n),
        .d_i   (fifo_rxf_n),
        .q_o   (rxf_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_txe (
        .clk_i (clk_12mhz),
        .rst_ni(reset_n),
        .d_i   (fifo_txe_n),
        .q_o   (txe_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_pwren (
        .clk_i (clk_12mhz),
        .rst_ni(reset_n),
        .d_i   (usb_pwren_n),
        .q_o   (pwren_s)
    );

    ftdi_state_e     state_d, state_q;
    last_op_e        last_op_d, last_op_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic            rd_n_d, rd_n_q;
    logic            wr_n_d, wr_n_q;
    logic            d_oe_d, d_oe_q;
    logic [7:0]      d_out_d, d_out_q;
    logic [7:0]      rx_data_d, rx_data_q;
    logic            rx_valid_d, rx_valid_q;
    logic            rd_elig, wr_elig, do_rd, do_wr;
`ifdef FTDI_SIWU_EN
    logic            flush_pend_d, flush_pend_q;
    logic            siwu_d, siwu_q;
`endif

    always_comb begin
        state_d    = state_q;
        last_op_d  = last_op_q;
        cnt_d      = cnt_q;
        rd_n_d     = rd_n_q;
        wr_n_d     = wr_n_q;
        d_oe_d     = d_oe_q;
        d_out_d    = d_out_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~rx_ready;
        tx_ready   = 1'b0;
`ifdef FTDI_SIWU_EN
        flush_pend_d = flush_pend_q | tx_flush;
        siwu_d       = 1'b1;
`endif
        rd_elig = ~rxf_s & ~rx_valid_q & ~pwren_s;
        wr_elig = ~txe_s & tx_valid & ~pwren_s;
        // Round-robin: on contention take whichever op was not done last.
        do_rd   = rd_elig & (~wr_elig | (last_op_q == LastWr));
        do_wr   = wr_elig & ~do_rd;

        unique case (state_q)
            StIdle: begin
                if (do_rd) begin
                    rd_n_d    = 1'b0;
                    last_op_d = LastRd;
                    state_d   = StRdStrobe;
                end else if (do_wr) begin
                    tx_ready  = 1'b1;
                    d_out_d   = tx_data;
                    d_oe_d    = 1'b1;
                    last_op_d = LastWr;
                    state_d   = StWrSetup;
                end
`ifdef FTDI_SIWU_EN
                else if (flush_pend_q) begin
                    siwu_d       = 1'b0;
                    flush_pend_d = tx_flush;
                    cnt_d        = '0;
                    state_d      = StRecover;
                end
`endif
            end
            StRdStrobe: state_d = StRdLatch;
            StRdLatch: begin
                rx_data_d  = fifo_d_in;
                rx_valid_d = 1'b1;
                rd_n_d     = 1'b1;
                cnt_d      = '0;
                state_d    = StRecover;
            end
            StWrSetup: begin
                wr_n_d  = 1'b0;
                state_d = StWrStrobe;
            end
            StWrStrobe: begin
                wr_n_d  = 1'b1;
                d_oe_d  = 1'b0;
                cnt_d   = '0;
                state_d = StRecover;
            end
            StRecover: begin
                // Gives released RXF#/TXE# time to propagate through the synchronisers.
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            last_op_q  <= LastWr;
            cnt_q      <= '0;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            d_oe_q     <= 1'b0;
            d_out_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_op_q  <= last_op_d;
            cnt_q      <= cnt_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            d_oe_q     <= d_oe_d;
            d_out_q    <= d_out_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

`ifdef FTDI_SIWU_EN
    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            flush_pend_q <= 1'b0;
            siwu_q       <= 1'b1;
        end else begin
            flush_pend_q <= flush_pend_d;
            siwu_q       <= siwu_d;
        end
    end

    assign fifo_siwu = siwu_q;
`else
    logic unused_tx_flush;
    assign unused_tx_flush = tx_flush;
    assign fifo_siwu       = 1'b1;
`endif

    assign fifo_d_out = d_out_q;
    assign fifo_d_oe  = d_oe_q;
    assign fifo_rd_n  = rd_n_q;
    assign fifo_wr_n  = wr_n_q;
    assign fifo_oe_n  = 1'b1;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;

endmodule

// File: tb/tb_ftdi_async_fifo_if.sv
// Directed bench for ftdi_async_fifo_if with a small FT232H async-FIFO model.
`timescale 1ns/1ps
module tb_ftdi_async_fifo_if;

    logic       clk_12mhz = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] fifo_d_in = 8'h00;
    logic [7:0] fifo_d_out;
    logic       fifo_d_oe;
    logic       fifo_rxf_n = 1'b1;
    logic       fifo_txe_n = 1'b1;
    logic       fifo_rd_n, fifo_wr_n, fifo_siwu, fifo_oe_n;
    logic       usb_pwren_n = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_flush = 1'b0;

    ftdi_async_fifo_if dut (
        .clk_12mhz  (clk_12mhz),
        .reset_n    (reset_n),
        .fifo_d_in  (fifo_d_in),
        .fifo_d_out (fifo_d_out),
        .fifo_d_oe  (fifo_d_oe),
        .fifo_rxf_n (fifo_rxf_n),
        .fifo_txe_n (fifo_txe_n),
        .fifo_rd_n  (fifo_rd_n),
        .fifo_wr_n  (fifo_wr_n),
        .fifo_siwu  (fifo_siwu),
        .fifo_oe_n  (fifo_oe_n),
        .usb_pwren_n(usb_pwren_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_flush   (tx_flush)
    );

    always #42 clk_12mhz = ~clk_12mhz;

    // FTDI model and observation logs, all sampled on the falling edge.
    logic [7:0]  rx_src[$];
    logic        txe_block = 1'b1;
    logic        prev_rd = 1'b1, prev_wr = 1'b1, prev_d_oe = 1'b0, prev_siwu = 1'b1;
    logic [7:0]  prev_d_out = 8'h00;
    int          rd_low = 0, wr_low = 0;
    int          rd_len[$], wr_len[$];
    logic [7:0]  rx_log[$];
    logic [17:0] wr_rec[$];
    logic [7:0]  op_log[$];
    int          siwu_lows = 0;
    int          tx_ready_cnt = 0;
    logic        siwu_after_wr = 1'b0;
    logic        excl_viol = 1'b0;

    always @(negedge clk_12mhz) begin
        if (fifo_d_oe && !fifo_rd_n) excl_viol = 1'b1;
        if (tx_ready) tx_ready_cnt++;
        if (rx_valid && rx_ready) rx_log.push_back(rx_data);
        if (!fifo_siwu) begin
            siwu_lows++;
            if (prev_siwu) siwu_after_wr = (op_log.size() > 0) && (op_log[$] == "W");
        end
        if (!fifo_rd_n) begin
            if (prev_rd) op_log.push_back("R");
            rd_low++;
            fifo_rxf_n = (rx_src.size() == 0);
        end else if (!prev_rd) begin
            rd_len.push_back(rd_low);
            rd_low = 0;
            if (rx_src.size() > 0) void'(rx_src.pop_front());
            fifo_rxf_n = 1'b1;
        end else begin
            fifo_rxf_n = (rx_src.size() == 0);
        end
        fifo_d_in = (rx_src.size() > 0) ? rx_src[0] : 8'h00;
        if (!fifo_wr_n) begin
            if (prev_wr) begin
                op_log.push_back("W");
                wr_rec.push_back({prev_d_oe, prev_d_out, fifo_d_oe, fifo_d_out});
            end
            wr_low++;
            fifo_txe_n = txe_block;
        end else if (!prev_wr) begin
            wr_len.push_back(wr_low);
            wr_low = 0;
            fifo_txe_n = 1'b1;
        end else begin
            fifo_txe_n = txe_block;
        end
        prev_rd    = fifo_rd_n;
        prev_wr    = fifo_wr_n;
        prev_d_oe  = fifo_d_oe;
        prev_d_out = fifo_d_out;
        prev_siwu  = fifo_siwu;
    end

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk_12mhz);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_12mhz);
    endtask

    logic ok;
    logic unstable;

    initial begin
        // 1: reset held with data waiting in the FTDI
        rx_src.push_back(8'hA5);
        rx_src.push_back(8'h5A);
        rx_src.push_back(8'hFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_12mhz);
            check("reset_outputs",
                  {25'd0, fifo_rd_n, fifo_wr_n, fifo_siwu, fifo_oe_n, fifo_d_oe, rx_valid, tx_ready},
                  {25'd0, 7'b1111000});
        end
        check("reset_d_out", {24'd0, fifo_d_out}, 32'h0);

        // 2: read three bytes with rx_ready held high
        drive_edge();
        reset_n  = 1'b1;
        rx_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_12mhz);
            ok = (rx_log.size() >= 3);
        end
        check("read3_timeout", {31'd0, ok}, 32'd1);
        check("read3_byte0", {24'd0, rx_log[0]}, 32'hA5);
        check("read3_byte1", {24'd0, rx_log[1]}, 32'h5A);
        check("read3_byte2", {24'd0, rx_log[2]}, 32'hFF);
        idle_cycles(10);
        check("read3_pulses", rd_len.size(), 32'd3);
        check("read3_rd_len0", rd_len[0], 32'd2);
        check("read3_rd_len2", rd_len[2], 32'd2);

        // 3: backpressure, two bytes waiting, consumer stalled
        drive_edge();
        rx_ready = 1'b0;
        rx_log.delete();
        rd_len.delete();
        rx_src.push_back(8'h11);
        rx_src.push_back(8'h22);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_12mhz);
            ok = rx_valid;
        end
        check("bp_valid_timeout", {31'd0, ok}, 32'd1);
        unstable = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_12mhz);
            if (!rx_valid || rx_data !== 8'h11) unstable = 1'b1;
        end
        check("bp_held_stable", {31'd0, unstable}, 32'd0);
        check("bp_one_pulse", rd_len.size() + (fifo_rd_n ? 0 : 1), 32'd1);
        drive_edge();
        rx_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk_12mhz);
            ok = (rx_log.size() >= 2);
        end
        check("bp_drain_timeout", {31'd0, ok}, 32'd1);
        check("bp_byte0", {24'd0, rx_log[0]}, 32'h11);
        check("bp_byte1", {24'd0, rx_log[1]}, 32'h22);

        // 4: single write of 0x3C
        idle_cycles(8);
        drive_edge();
        tx_ready_cnt = 0;
        txe_block = 1'b0;
        tx_data   = 8'h3C;
        tx_valid  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk_12mhz);
            ok = tx_ready;
        end
        check("wr_ready_timeout", {31'd0, ok}, 32'd1);
        drive_edge();
        tx_valid = 1'b0;
        tx_data  = 8'hEE;
        idle_cycles(12);
        check("wr_ready_pulses", tx_ready_cnt, 32'd1);
        check("wr_count", wr_rec.size(), 32'd1);
        check("wr_setup_and_strobe", {14'd0, wr_rec[0]}, {14'd0, 1'b1, 8'h3C, 1'b1, 8'h3C});
        check("wr_strobe_len", wr_len[0], 32'd1);
        check("wr_d_oe_released", {31'd0, fifo_d_oe}, 32'd0);

        // 5: contention, both sides eligible once USB becomes configured
        drive_edge();
        usb_pwren_n = 1'b1;
        idle_cycles(4);
        drive_edge();
        op_log.delete();
        for (int i = 1; i <= 4; i++) rx_src.push_back(8'(i));
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        idle_cycles(10);
        check("pwren_blocks_ops", op_log.size(), 32'd0);
        drive_edge();
        usb_pwren_n = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_12mhz);
            ok = (op_log.size() >= 4);
        end
        drive_edge();
        tx_valid = 1'b0;
        check("rr_timeout", {31'd0, ok}, 32'd1);
        check("rr_op0", {24'd0, op_log[0]}, {24'd0, 8'h52});
        check("rr_op1", {24'd0, op_log[1]}, {24'd0, 8'h57});
        check("rr_op2", {24'd0, op_log[2]}, {24'd0, 8'h52});
        check("rr_op3", {24'd0, op_log[3]}, {24'd0, 8'h57});
        idle_cycles(60);

        // 6: write then flush request
        drive_edge();
        siwu_lows = 0;
        tx_data   = 8'h01;
        tx_valid  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk_12mhz);
            ok = tx_ready;
        end
        check("flush_wr_timeout", {31'd0, ok}, 32'd1);
        drive_edge();
        tx_valid = 1'b0;
        tx_flush = 1'b1;
        drive_edge();
        tx_flush = 1'b0;
        idle_cycles(20);
`ifdef FTDI_SIWU_EN
        check("siwu_single_pulse", siwu_lows, 32'd1);
        check("siwu_after_write", {31'd0, siwu_after_wr}, 32'd1);
`else
        check("siwu_tied_high", siwu_lows, 32'd0);
`endif

        // Reset asserted in the middle of a read strobe
        drive_edge();
        rx_src.push_back(8'h99);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_12mhz);
            ok = !fifo_rd_n;
        end
        check("midrst_rd_seen", {31'd0, ok}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_outputs", {28'd0, fifo_rd_n, fifo_wr_n, fifo_d_oe, rx_valid},
              {28'd0, 4'b1100});
        check("no_oe_during_read", {31'd0, excl_viol}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
